// File: rtl/imm_ext_defs.sv
// rtl/imm_ext_defs.sv - OP_SE extension mode encodings shared by imm_extend_pipe
//
// Purpose: the eight OP_SE codes; six real extension modes and two reserved
// codes that produce an error result instead of an immediate.
// Ports: none (package).
package imm_ext_defs;

    localparam int OP_SE_W = 3;

    typedef enum logic [OP_SE_W-1:0] {
        OP_SEXT_SHORT = 3'b000,  // sign-extend the short field
        OP_SEXT_FULL  = 3'b001,  // sign-extend the whole input
        OP_ZEXT_SHORT = 3'b010,  // zero-extend the short field
        OP_ZEXT_FULL  = 3'b011,  // zero-extend the whole input
        OP_BRANCH     = 3'b100,  // sign-extend whole input, then << 2
        OP_UPPER      = 3'b101,  // input in the top bits, low bits zero
        OP_RSVD6      = 3'b110,
        OP_RSVD7      = 3'b111
    } op_se_e;

    function automatic logic op_is_reserved(input op_se_e op);
        return (op == OP_RSVD6) || (op == OP_RSVD7);
    endfunction

endpackage

// File: rtl/imm_ext_stage.sv
// rtl/imm_ext_stage.sv - one-entry valid/ready register slice
//
// Purpose: holds one data word; loads whenever it is empty or its content is
// being taken downstream in the same cycle, so it sustains one word per cycle.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   in_data_i/valid_i upstream word and its valid
//   in_ready_o        slice can take a word this cycle
//   out_data_o/valid_o registered word and valid (data is 0 when not valid)
//   out_ready_i       downstream takes the word this cycle
module imm_ext_stage #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] in_data_i,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    output logic [W-1:0] out_data_o,
    output logic         out_valid_o,
    input  logic         out_ready_i
);

    logic         valid_q, valid_d;
    logic [W-1:0] data_q,  data_d;

    // Ready depends only on own state and downstream ready, never on in_valid_i.
    assign in_ready_o  = !valid_q || out_ready_i;
    assign out_valid_o = valid_q;
    assign out_data_o  = data_q;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (in_ready_o) begin
            valid_d = in_valid_i;
            // Clear the data when emptying so an idle slice presents zero.
            data_d  = in_valid_i ? in_data_i : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: rtl/imm_extend_pipe.sv
// rtl/imm_extend_pipe.sv - two-stage immediate extension pipeline
//
// Purpose: stage 1 registers {OP_SE, in}; the extension arithmetic sits between
// the stages; stage 2 registers {out_err, out}. Two cycles of latency, one
// result per cycle, valid/ready flow control on both sides.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   in, OP_SE, in_valid   raw immediate, extension mode, valid
//   in_ready              block accepts input this cycle (0 during rst)
//   out, out_err          extended immediate, reserved-mode flag (0 when idle)
//   out_valid, out_ready  output handshake
module imm_extend_pipe
    import imm_ext_defs::*;
#(
    parameter int IN_W    = 16,
    parameter int OUT_W   = 32,
    parameter int SHORT_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [IN_W-1:0]   in,
    input  logic [2:0]        OP_SE,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [OUT_W-1:0]  out,
    output logic              out_err,
    output logic              out_valid,
    input  logic              out_ready
);

    localparam int S1_W = IN_W + OP_SE_W;
    localparam int S2_W = OUT_W + 1;

    logic             s1_in_ready;
    logic             s1_valid;
    logic [S1_W-1:0]  s1_data;
    logic             s2_in_ready;
    logic [S2_W-1:0]  s2_data;

    op_se_e           s1_op;
    logic [IN_W-1:0]  s1_imm;
    logic [OUT_W-1:0] sext_full;
    logic [OUT_W-1:0] ext_out;
    logic             ext_err;

    imm_ext_stage #(.W(S1_W)) u_stage1 (
        .clk         (clk),
        .rst         (rst),
        .in_data_i   ({OP_SE, in}),
        .in_valid_i  (in_valid),
        .in_ready_o  (s1_in_ready),
        .out_data_o  (s1_data),
        .out_valid_o (s1_valid),
        .out_ready_i (s2_in_ready)
    );

    // Nothing is accepted while reset is held.
    assign in_ready = s1_in_ready && !rst;

    assign s1_op  = op_se_e'(s1_data[S1_W-1:IN_W]);
    assign s1_imm = s1_data[IN_W-1:0];

    always_comb begin
        sext_full = {{(OUT_W-IN_W){s1_imm[IN_W-1]}}, s1_imm};
        ext_out   = '0;
        ext_err   = op_is_reserved(s1_op);
        case (s1_op)
            OP_SEXT_SHORT: ext_out = {{(OUT_W-SHORT_W){s1_imm[SHORT_W-1]}}, s1_imm[SHORT_W-1:0]};
            OP_SEXT_FULL:  ext_out = sext_full;
            OP_ZEXT_SHORT: ext_out = {{(OUT_W-SHORT_W){1'b0}}, s1_imm[SHORT_W-1:0]};
            OP_ZEXT_FULL:  ext_out = {{(OUT_W-IN_W){1'b0}}, s1_imm};
            // Bits shifted past the top are simply dropped.
            OP_BRANCH:     ext_out = sext_full << 2;
            OP_UPPER:      ext_out = {s1_imm, {(OUT_W-IN_W){1'b0}}};
            default:       ext_out = '0;
        endcase
    end

    imm_ext_stage #(.W(S2_W)) u_stage2 (
        .clk         (clk),
        .rst         (rst),
        .in_data_i   ({ext_err, ext_out}),
        .in_valid_i  (s1_valid),
        .in_ready_o  (s2_in_ready),
        .out_data_o  (s2_data),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready)
    );

    assign out_err = s2_data[S2_W-1];
    assign out     = s2_data[OUT_W-1:0];

endmodule

// File: doc/imm_extend_pipe.md
IMM_EXTEND_PIPE -- requirements
Module: imm_extend_pipe

Interface
REQ-001 SHALL have parameter IN_W, default 16, immediate input width.
REQ-002 SHALL have parameter OUT_W, default 32, extended output width; OUT_W > IN_W.
REQ-003 SHALL have parameter SHORT_W, default 12, short immediate field width; SHORT_W < IN_W.
REQ-004 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port in  input  IN_W  raw immediate field.
REQ-007 SHALL have port OP_SE  input  3  extension mode.
REQ-008 SHALL have port in_valid  input  1  in/OP_SE valid this cycle.
REQ-009 SHALL have port in_ready  output  1  block accepts input this cycle.
REQ-010 SHALL have port out  output  OUT_W  extended immediate.
REQ-011 SHALL have port out_err  output  1  out produced from a reserved OP_SE.
REQ-012 SHALL have port out_valid  output  1  out/out_err valid.
REQ-013 SHALL have port out_ready  input  1  consumer accepts out this cycle.

Function
REQ-014 Modes: 000 sign-extend in[SHORT_W-1:0]; 001 sign-extend in[IN_W-1:0]; 010 zero-extend in[SHORT_W-1:0]; 011 zero-extend in[IN_W-1:0]; 100 sign-extend in[IN_W-1:0] then shift left 2 (branch offset); 101 in placed in out[OUT_W-1:OUT_W-IN_W], low bits zero (upper immediate).
REQ-015 Modes 110/111 SHALL produce out = 0 and out_err = 1; all other modes out_err = 0.
REQ-016 Mode 100 SHALL discard the two bits shifted past OUT_W; no saturation.
REQ-017 Two-stage pipeline: stage 1 registers in/OP_SE, stage 2 registers computed out/out_err; latency exactly 2 cycles from accepted input to out_valid with no backpressure.
REQ-018 Transfer in SHALL occur only when in_valid && in_ready; transfer out only when out_valid && out_ready.
REQ-019 Stage 2 advances when !out_valid || out_ready; stage 1 advances when stage 1 empty or stage 2 advances; in_ready = !s1_valid || stage-2 advance.
REQ-020 Full throughput: one result per cycle sustained while out_ready = 1.
REQ-021 While out_valid && !out_ready, out, out_err SHALL remain stable; stage 1 holds its contents; at most 2 items are in flight.
REQ-022 Simultaneous accept and emit in one cycle SHALL lose and duplicate nothing; order SHALL be preserved.
REQ-023 in_ready SHALL never depend combinationally on in_valid.
REQ-024 When out_valid = 0, out and out_err SHALL be 0.

Reset
REQ-025 On clk edge with rst = 1: s1_valid = 0, out_valid = 0, out = 0, out_err = 0; stage-1 data cleared to 0.
REQ-026 rst mid-operation SHALL drop all in-flight items; no output for them appears after rst deasserts.
REQ-027 During rst, in_ready SHALL be 0; in the first cycle after rst deasserts, in_ready = 1.

Structure
REQ-028 The OP_SE mode encodings (6 modes, 2 reserved) SHALL be constants in a shared package/include imm_ext_defs, reused by the decoder.
REQ-029 Extension arithmetic SHALL be one combinational function/block; one sub-module imm_ext_stage (valid/ready register slice, parametrised width) SHALL be instantiated twice.
REQ-030 No latches; all extension logic fully assigned for every OP_SE.

Verification
REQ-031 in=16'h0800, OP_SE=000, out_ready=1 -> out=32'hFFFFF800, out_err=0, out_valid exactly 2 cycles after accept.
REQ-032 in=16'h8001 with modes 001, 011, 100, 101 back-to-back -> 32'hFFFF8001, 32'h00008001, 32'hFFFE0004, 32'h80010000, in order, one per cycle.
REQ-033 OP_SE=110, in=16'hFFFF -> out=0, out_err=1.
REQ-034 Stream 5 items, out_ready=0 for 4 cycles mid-stream -> in_ready falls after 2 items in flight, out held stable, all 5 delivered in order, none duplicated.
REQ-035 Assert rst with 2 items in flight -> next cycle out_valid=0, out=0; after rst deasserts no stale item appears; in_ready=1.
REQ-036 Random in/OP_SE/in_valid/out_ready for 10k cycles against a reference model -> zero mismatches, order preserved.
